// File: rtl/inst_loader.sv
// Boot-time program loader: framed byte stream -> instruction store writes.
// Holds the core in reset until a load completes with a good checksum.
module inst_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst
);

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       len;
    logic [15:0]       len_in;
    logic [ADDR_W:0]   word_idx;
    logic [ADDR_W:0]   word_nxt;
    logic [1:0]        byte_idx;
    logic [23:0]       asm_q;
    logic [7:0]        acc;
    logic              xfer;
    logic              go;

    assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI)
                     || (state == S_DATA)   || (state == S_CHK);
    assign busy       = byte_ready;
    assign done       = (state == S_DONE);
    assign err        = (state == S_ERR);
    assign cpu_rst    = (state != S_DONE);

    assign xfer     = byte_valid && byte_ready;
    assign go       = start && ((state == S_IDLE) || (state == S_DONE)
                             || (state == S_ERR));
    assign len_in   = {byte_data, len[7:0]};
    assign word_nxt = word_idx + {{ADDR_W{1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: frame parsing and length/checksum decisions
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (go) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if ({1'b0, len_in} > DEPTH) state_nxt = S_ERR;
                    else if (len_in == 16'd0)  state_nxt = S_CHK;
                    else                       state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && byte_idx == 2'd3 && 16'(word_nxt) == len)
                    state_nxt = S_CHK;
            end
            S_CHK: begin
                if (xfer) begin
                    if (byte_data == acc) state_nxt = S_DONE;
                    else                  state_nxt = S_ERR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: length latch, word assembly, checksum and write pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            asm_q     <= '0;
            acc       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (go) begin
                word_idx <= '0;
                byte_idx <= '0;
                acc      <= '0;
            end
            if (xfer && state == S_LEN_LO) len[7:0]  <= byte_data;
            if (xfer && state == S_LEN_HI) len[15:8] <= byte_data;
            if (xfer && state == S_DATA) begin
                acc      <= acc ^ byte_data;
                byte_idx <= byte_idx + 2'd1;
                unique case (byte_idx)
                    2'd0: asm_q[7:0]   <= byte_data;
                    2'd1: asm_q[15:8]  <= byte_data;
                    2'd2: asm_q[23:16] <= byte_data;
                    2'd3: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_idx[ADDR_W-1:0];
                        mem_wdata <= {byte_data, asm_q};
                        word_idx  <= word_nxt;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
